// File: rtl/shift_pipe_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : shift_pipe_ctrl_pkg                                       |
// | Brief  : shared widths, FIFO depth, command record, overflow helper |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
package shift_pipe_ctrl_pkg;

  localparam int DATA_W     = 8;
  localparam int AMT_W      = 3;
  localparam int FIFO_DEPTH = 2;
  localparam int CNT_W      = 8;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [AMT_W-1:0]  amount;
  } cmd_t;

  // A 1 is lost when any of the top 'amount' bits of data is set.
  // With amount == 0 the mask is empty, so no overflow is reported.
  function automatic logic ovf_of(input cmd_t c);
    logic [DATA_W-1:0] mask;
    mask = ~({DATA_W{1'b1}} >> c.amount);
    return |(c.data & mask);
  endfunction

endpackage
`default_nettype wire

// File: rtl/shift_pipe_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : shift_pipe_ctrl_if                                        |
// | Brief  : command, shifter and result bundle for shift_pipe_ctrl     |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
interface shift_pipe_ctrl_if;
  import shift_pipe_ctrl_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] din;
  logic [AMT_W-1:0]  sel;
  logic [DATA_W-1:0] sh_din;
  logic [AMT_W-1:0]  sh_sel;
  logic [DATA_W-1:0] sh_dout;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] dout;
  logic              ovf;
  logic [CNT_W-1:0]  cnt;

  // The block itself, including its view of the external shifter.
  modport slave (
    input  in_valid, din, sel, sh_dout, out_ready,
    output in_ready, sh_din, sh_sel, out_valid, dout, ovf, cnt
  );

  // Environment: upstream producer, downstream consumer and shifter.
  modport master (
    output in_valid, din, sel, sh_dout, out_ready,
    input  in_ready, sh_din, sh_sel, out_valid, dout, ovf, cnt
  );

endinterface
`default_nettype wire

// File: rtl/shift_fifo2.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : shift_fifo2                                               |
// | Brief  : 2-entry in-order command FIFO with zeroed head when empty  |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module shift_fifo2
  import shift_pipe_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  cmd_t push_data,
  input  logic pop,
  output cmd_t head,
  output logic full,
  output logic empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

  cmd_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;

  assign full  = (occ == OCC_W'(FIFO_DEPTH));
  assign empty = (occ == '0);
  // Downstream sees zeros rather than a stale entry when nothing is queued.
  assign head  = empty ? '0 : mem[rd_ptr];

  // Storage write; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at a power-of-two depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push && !full, pop && !empty})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/shift_pipe_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : shift_pipe_ctrl                                           |
// | Brief  : queues shift commands, drives an external shifter and      |
// |          registers result, overflow flag and handshake count        |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module shift_pipe_ctrl
  import shift_pipe_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  shift_pipe_ctrl_if.slave bus
);

  cmd_t              in_cmd;
  cmd_t              head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              res_free;
  logic              res_valid;
  logic [DATA_W-1:0] res_data;
  logic              res_ovf;
  logic [CNT_W-1:0]  hs_count;

  assign in_cmd = {bus.din, bus.sel};

  // Ready depends only on registered occupancy, so a same-cycle pop
  // never opens the input path combinationally.
  assign bus.in_ready = !fifo_full;
  assign push         = bus.in_valid && !fifo_full;
  assign res_free     = !res_valid || bus.out_ready;
  assign pop          = !fifo_empty && res_free;

  assign bus.sh_din    = head.data;
  assign bus.sh_sel    = head.amount;
  assign bus.out_valid = res_valid;
  assign bus.dout      = res_data;
  assign bus.ovf       = res_ovf;
  assign bus.cnt       = hs_count;

  shift_fifo2 u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (in_cmd),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Result register: load the shifted head when free, drain to invalid
  // when free with nothing queued, otherwise hold under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_ovf   <= 1'b0;
    end else if (res_free) begin
      if (!fifo_empty) begin
        res_valid <= 1'b1;
        res_data  <= bus.sh_dout;
        res_ovf   <= ovf_of(head);
      end else begin
        res_valid <= 1'b0;
      end
    end
  end

  // Completed output handshakes, wrapping modulo 2**CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_count <= '0;
    end else if (res_valid && bus.out_ready) begin
      hs_count <= hs_count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shift_pipe_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : tb_shift_pipe_ctrl                                        |
// | Brief  : directed self-checking bench for shift_pipe_ctrl           |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module tb_shift_pipe_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  int   exp_cnt;

  shift_pipe_ctrl_if bus ();

  // External combinational shifter, zero fill.
  assign bus.sh_dout = bus.sh_din << bus.sh_sel;

  shift_pipe_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference result {ovf, data} from a widened shift.
  function automatic logic [8:0] model(input logic [7:0] d, input logic [2:0] s);
    logic [15:0] w;
    w = {8'h00, d} << s;
    return {|w[15:8], w[7:0]};
  endfunction

  // Offer one command and wait (bounded) for its acceptance edge.
  task automatic offer(input logic [7:0] d, input logic [2:0] s);
    logic acc;
    acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.din      = d;
    bus.sel      = s;
    for (int i = 0; i < 20 && !acc; i++) begin
      acc = bus.in_ready;
      step();
    end
    if (!acc) check("offer_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
  endtask

  // One command through an empty pipe with out_ready held high.
  task automatic send_one(input string tag, input logic [7:0] d, input logic [2:0] s,
                          input logic [8:0] exp);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.din       = d;
    bus.sel       = s;
    step();
    bus.in_valid = 1'b0;
    check({tag, "_lat0"}, {31'd0, bus.out_valid}, 32'd0);
    step();
    check({tag, "_vld"}, {31'd0, bus.out_valid}, 32'd1);
    check({tag, "_res"}, {23'd0, bus.ovf, bus.dout}, {23'd0, exp});
    step();
    exp_cnt++;
    check({tag, "_cnt"}, {24'd0, bus.cnt}, exp_cnt);
    check({tag, "_drain"}, {31'd0, bus.out_valid}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  initial begin
    int sent;
    int recv;
    int first_hs;
    int last_hs;
    int seen;
    logic [8:0] exp_q[$];

    n_checks      = 0;
    n_pass        = 0;
    exp_cnt       = 0;
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.din       = 8'h00;
    bus.sel       = 3'd0;
    bus.out_ready = 1'b0;

    // Reset state
    do_reset();
    check("rst_vld",   {31'd0, bus.out_valid}, 32'd0);
    check("rst_dout",  {24'd0, bus.dout},      32'd0);
    check("rst_ovf",   {31'd0, bus.ovf},       32'd0);
    check("rst_cnt",   {24'd0, bus.cnt},       32'd0);
    check("rst_rdy",   {31'd0, bus.in_ready},  32'd1);
    check("rst_shdin", {24'd0, bus.sh_din},    32'd0);
    check("rst_shsel", {29'd0, bus.sh_sel},    32'd0);

    // Single commands and overflow corners
    send_one("single", 8'h0F, 3'd4, 9'h0F0);
    send_one("ovf81",  8'h81, 3'd1, 9'h102);
    send_one("sel7",   8'h01, 3'd7, 9'h080);
    send_one("sel0",   8'hFF, 3'd0, 9'h0FF);
    send_one("a5s3",   8'hA5, 3'd3, 9'h128);

    // Backpressure: three fit, fourth stalls until the output drains
    bus.out_ready = 1'b0;
    offer(8'h12, 3'd1);
    offer(8'hC3, 3'd2);
    offer(8'h3C, 3'd5);
    check("bp_full_rdy", {31'd0, bus.in_ready}, 32'd0);
    check("bp_hold0", {22'd0, bus.out_valid, bus.ovf, bus.dout}, {22'd0, 10'h224});
    bus.in_valid = 1'b1;
    bus.din      = 8'h55;
    bus.sel      = 3'd6;
    step();
    step();
    check("bp_stall_rdy", {31'd0, bus.in_ready}, 32'd0);
    check("bp_hold1", {22'd0, bus.out_valid, bus.ovf, bus.dout}, {22'd0, 10'h224});
    check("bp_cnt_hold", {24'd0, bus.cnt}, exp_cnt);
    bus.out_ready = 1'b1;
    step();
    check("bp_r1", {22'd0, bus.out_valid, bus.ovf, bus.dout}, {22'd0, 10'h30C});
    check("bp_rdy_back", {31'd0, bus.in_ready}, 32'd1);
    step();
    bus.in_valid = 1'b0;
    check("bp_r2", {22'd0, bus.out_valid, bus.ovf, bus.dout}, {22'd0, 10'h380});
    check("bp_4th_acc", {24'd0, bus.sh_din}, 32'h55);
    step();
    check("bp_r3", {22'd0, bus.out_valid, bus.ovf, bus.dout}, {22'd0, 10'h340});
    step();
    check("bp_empty", {31'd0, bus.out_valid}, 32'd0);
    check("bp_cnt", {24'd0, bus.cnt}, exp_cnt + 4);

    // Streaming 300 commands, one per cycle
    do_reset();
    bus.out_ready = 1'b1;
    sent     = 0;
    recv     = 0;
    first_hs = -1;
    last_hs  = -1;
    for (int cyc = 0; cyc < 320 && recv < 300; cyc++) begin
      bus.in_valid = (sent < 300);
      bus.din      = sent[7:0];
      bus.sel      = sent[2:0];
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("stream_extra", 32'd1, 32'd0);
        end else begin
          check("stream_res", {23'd0, bus.ovf, bus.dout}, {23'd0, exp_q.pop_front()});
        end
        recv++;
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.din, bus.sel));
        sent++;
      end
      step();
    end
    bus.in_valid = 1'b0;
    check("stream_recv", recv, 32'd300);
    check("stream_span", last_hs - first_hs, 32'd299);
    check("stream_cnt_wrap", {24'd0, bus.cnt}, 32'd44);

    // Reset with FIFO full and a result pending
    step();
    step();
    bus.out_ready = 1'b0;
    offer(8'h11, 3'd1);
    offer(8'h22, 3'd2);
    offer(8'h33, 3'd3);
    check("mid_pre_rdy", {31'd0, bus.in_ready},  32'd0);
    check("mid_pre_vld", {31'd0, bus.out_valid}, 32'd1);
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.din       = 8'hAA;
    bus.sel       = 3'd1;
    bus.out_ready = 1'b1;
    step();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    check("mid_vld",   {31'd0, bus.out_valid}, 32'd0);
    check("mid_cnt",   {24'd0, bus.cnt},       32'd0);
    check("mid_rdy",   {31'd0, bus.in_ready},  32'd1);
    check("mid_shsel", {29'd0, bus.sh_sel},    32'd0);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.out_valid) seen++;
    end
    check("mid_no_stale", seen, 32'd0);
    check("mid_cnt_hold", {24'd0, bus.cnt}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shift_pipe_ctrl.md
SHIFT_PIPE_CTRL -- requirements
Module: shift_pipe_ctrl

Interface
REQ-001 The block SHALL have one clock, CLK, and one reset, RST, which is synchronous and active-high.
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 RST  input  1  synchronous active-high reset.
REQ-004 IN_VALID  input  1  upstream offers a shift command.
REQ-005 IN_READY  output  1  block accepts a command this cycle.
REQ-006 DIN  input  8  data byte to shift left.
REQ-007 SEL  input  3  left-shift amount, 0..7.
REQ-008 SH_DIN  output  8  data to the external combinational left shifter.
REQ-009 SH_SEL  output  3  shift amount to the external shifter.
REQ-010 SH_DOUT  input  8  result from the external shifter (SH_DIN << SH_SEL, zero fill).
REQ-011 OUT_VALID  output  1  DOUT, OVF and CNT hold a valid result.
REQ-012 OUT_READY  input  1  downstream accepts the result.
REQ-013 DOUT  output  8  registered shift result.
REQ-014 OVF  output  1  registered flag: a 1 bit was shifted out past bit 7.
REQ-015 CNT  output  8  count of completed output handshakes.

Function
REQ-016 A command SHALL be accepted at a rising edge where IN_VALID=1 and IN_READY=1; acceptance writes {DIN,SEL} into a 2-entry in-order FIFO.
REQ-017 IN_READY SHALL be a function of registered FIFO occupancy only: it is 1 when occupancy is below 2, and 0 when occupancy is 2, even if a pop occurs in the same cycle.
REQ-018 SH_DIN and SH_SEL SHALL show the FIFO head combinationally; when the FIFO is empty they SHALL be 0.
REQ-019 The output register SHALL be free when OUT_VALID=0, or when OUT_VALID=1 and OUT_READY=1 in the same cycle.
REQ-020 At an edge where the FIFO is non-empty and the output register is free:
- pop the FIFO head;
- load DOUT <= SH_DOUT;
- load OVF <= OR of head DIN[7:8-SEL] when SEL != 0, else 0;
- set OUT_VALID=1.
REQ-021 At an edge where the output register is free and the FIFO is empty, OUT_VALID SHALL become 0; DOUT and OVF hold their last values.
REQ-022 While OUT_VALID=1 and OUT_READY=0, DOUT, OVF and OUT_VALID SHALL hold stable.
REQ-023 Latency: a command accepted at edge k with the pipe empty SHALL show OUT_VALID=1 after edge k+1.
REQ-024 Sustained throughput SHALL be one result per cycle when IN_VALID=1 and OUT_READY=1 continuously.
REQ-025 When push and pop happen at the same edge, FIFO occupancy SHALL be unchanged and order preserved.
REQ-026 CNT SHALL increment by 1 at each edge with OUT_VALID=1 and OUT_READY=1, wrapping from 255 to 0.
REQ-027 Capacity SHALL be 3 commands in flight (2 FIFO entries plus 1 output register); no command is dropped or duplicated.

Reset
REQ-028 On RST=1 at a rising edge, the block SHALL clear FIFO occupancy and pointers and set OUT_VALID=0, DOUT=0, OVF=0 and CNT=0; after that edge IN_READY=1 and SH_DIN=SH_SEL=0.
REQ-029 Reset SHALL take priority over any concurrent handshake; commands in flight at reset are discarded.

Structure
REQ-030 The data width (8), shift-amount width (3) and FIFO depth (2) SHALL be constants in a shared package, together with a command record type {data, amount}.
REQ-031 The FIFO SHALL be a separate sub-module, shift_fifo2, with push/pop/full/empty signals and head output; the shifter SHALL stay external to this block.

Verification
REQ-032 Single command: DIN=0x0F, SEL=4 accepted with OUT_READY=1 -> DOUT=0xF0, OVF=0, OUT_VALID=1 one edge after acceptance, and CNT=1 after the handshake.
REQ-033 Overflow: DIN=0x81, SEL=1 -> DOUT=0x02, OVF=1; DIN=0x01, SEL=7 -> DOUT=0x80, OVF=0; DIN=0xFF, SEL=0 -> DOUT=0xFF, OVF=0.
REQ-034 Backpressure: OUT_READY=0, offer 4 commands back-to-back -> 3 accepted, IN_READY=0 from the edge after the 3rd; then OUT_READY=1 -> the 3 results emerge in order on consecutive cycles and the 4th is then accepted.
REQ-035 Streaming: 300 commands with IN_VALID=OUT_READY=1 -> one result per cycle, and CNT wraps to 44 after the 300th handshake.
REQ-036 Reset mid-operation: assert RST with the FIFO full and OUT_VALID=1 -> after that edge OUT_VALID=0, CNT=0, IN_READY=1 and SH_SEL=0; no stale result appears afterwards.
